// File: rtl/seq_pkg.sv
// Shared decode constants, FSM state and run-status encodings for the
// datapath sequencer, plus the instruction classifier used in EXEC.
package seq_pkg;
  localparam logic [6:0]  OP_IMM      = 7'b0010011;
  localparam logic [6:0]  OP_REG      = 7'b0110011;
  localparam logic [6:0]  OP_BRANCH   = 7'b1100011;
  localparam logic [2:0]  F3_ADDI     = 3'b000;
  localparam logic [2:0]  F3_ADD      = 3'b000;
  localparam logic [2:0]  F3_BNE      = 3'b001;
  localparam logic [6:0]  F7_ADD      = 7'b0000000;
  localparam logic [31:0] EBREAK_WORD = 32'h00100073;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_DONE} state_t;
  typedef enum logic [1:0] {ST_OK, ST_ILLEGAL, ST_MISALIGN, ST_TIMEOUT} status_t;
  typedef enum logic [2:0] {K_ADDI, K_ADD, K_BNE, K_EBREAK, K_ILLEGAL} kind_t;

  // Anything not exactly one of the supported encodings is illegal.
  function automatic kind_t decode(input logic [31:0] w);
    if (w == EBREAK_WORD) return K_EBREAK;
    if (w[6:0] == OP_IMM && w[14:12] == F3_ADDI) return K_ADDI;
    if (w[6:0] == OP_REG && w[14:12] == F3_ADD && w[31:25] == F7_ADD) return K_ADD;
    if (w[6:0] == OP_BRANCH && w[14:12] == F3_BNE) return K_BNE;
    return K_ILLEGAL;
  endfunction
endpackage

// File: rtl/datapath_sequencer_if.sv
// Sequencer <-> datapath/ROM bus: register addresses, write enable,
// operand select, immediate, equality flag and instruction fetch.
interface datapath_sequencer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADD_WIDTH  = 5,
  parameter int PC_WIDTH   = 8
);
  logic [PC_WIDTH-1:0]   instr_addr;
  logic [31:0]           instr_data;
  logic [ADD_WIDTH-1:0]  AD1, AD2, AD3;
  logic                  WE3;
  logic                  ALUsrc;
  logic [DATA_WIDTH-1:0] Immop;
  logic                  EQ;

  modport master (
    output instr_addr, AD1, AD2, AD3, WE3, ALUsrc, Immop,
    input  instr_data, EQ
  );
  modport slave (
    input  instr_addr, AD1, AD2, AD3, WE3, ALUsrc, Immop,
    output instr_data, EQ
  );
endinterface

// File: rtl/imm_gen.sv
// Sign-extended I-type and B-type immediates from the instruction register.
module imm_gen #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [31:0]           ir,
  output logic [DATA_WIDTH-1:0] imm_i,
  output logic [DATA_WIDTH-1:0] imm_b
);
  logic unused_bits;

  assign imm_i = {{(DATA_WIDTH-12){ir[31]}}, ir[31:20]};
  assign imm_b = {{(DATA_WIDTH-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign unused_bits = ^{ir[19:12], ir[6:0]};
endmodule

// File: rtl/datapath_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC controller for addi/add/bne/ebreak.
// Register addresses come straight from ir, so they hold the last
// instruction's fields outside EXEC without extra state.
module datapath_sequencer
  import seq_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADD_WIDTH  = 5,
  parameter int PC_WIDTH   = 8,
  parameter int MAX_STEPS  = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           status,
  datapath_sequencer_if.master dp
);
  localparam int SW = $clog2(MAX_STEPS + 1);

  state_t                state, state_d;
  status_t               status_q, status_d;
  kind_t                 kind;
  logic [PC_WIDTH-1:0]   pc, pc_d, pc_plus4, br_tgt;
  logic [31:0]           ir;
  logic [SW-1:0]         steps, steps_d, steps_nx;
  logic                  done_q, done_d;
  logic                  rd_nz, we3, alusrc;
  logic [DATA_WIDTH-1:0] imm_i, imm_b, immop;

  imm_gen #(.DATA_WIDTH(DATA_WIDTH)) u_imm (
    .ir    (ir),
    .imm_i (imm_i),
    .imm_b (imm_b)
  );

  assign kind     = decode(ir);
  assign rd_nz    = (ir[11:7] != 5'd0);
  assign pc_plus4 = pc + PC_WIDTH'(4);
  assign br_tgt   = pc + imm_b[PC_WIDTH-1:0];
  assign steps_nx = steps + SW'(1);

  // State, pc, ir, step counter and run result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      pc       <= '0;
      ir       <= '0;
      steps    <= '0;
      done_q   <= 1'b0;
      status_q <= ST_OK;
    end else begin
      state    <= state_d;
      pc       <= pc_d;
      steps    <= steps_d;
      done_q   <= done_d;
      status_q <= status_d;
      if (state == S_DECODE) ir <= dp.instr_data;
    end
  end

  // Next-state, pc update and EXEC-cycle datapath controls.
  always_comb begin
    state_d  = state;
    pc_d     = pc;
    steps_d  = steps;
    done_d   = done_q;
    status_d = status_q;
    we3      = 1'b0;
    alusrc   = 1'b0;
    immop    = '0;
    case (state)
      S_IDLE: begin
        if (start) begin
          done_d   = 1'b0;
          pc_d     = '0;
          steps_d  = '0;
          status_d = ST_OK;
          state_d  = S_FETCH;
        end
      end
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        state_d = S_FETCH;
        case (kind)
          K_ADDI: begin
            alusrc = 1'b1;
            immop  = imm_i;
            we3    = rd_nz;
            pc_d   = pc_plus4;
          end
          K_ADD: begin
            we3  = rd_nz;
            pc_d = pc_plus4;
          end
          K_BNE: begin
            immop = imm_b;
            if (dp.EQ) begin
              pc_d = pc_plus4;
            end else if (br_tgt[1:0] != 2'b00) begin
              // misaligned target: stop with pc left on the branch
              state_d  = S_DONE;
              status_d = ST_MISALIGN;
            end else begin
              pc_d = br_tgt;
            end
          end
          K_EBREAK: begin
            state_d  = S_DONE;
            status_d = ST_OK;
          end
          default: begin
            state_d  = S_DONE;
            status_d = ST_ILLEGAL;
          end
        endcase
        // Still heading to FETCH means the instruction retired.
        if (state_d == S_FETCH) begin
          steps_d = steps_nx;
          if (steps_nx == SW'(MAX_STEPS)) begin
            state_d  = S_DONE;
            status_d = ST_TIMEOUT;
          end
        end
        if (state_d == S_DONE) done_d = 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy          = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC);
  assign done          = done_q;
  assign status        = status_q;
  assign dp.instr_addr = pc;
  assign dp.AD1        = ADD_WIDTH'(ir[19:15]);
  assign dp.AD2        = ADD_WIDTH'(ir[24:20]);
  assign dp.AD3        = ADD_WIDTH'(ir[11:7]);
  assign dp.WE3        = we3;
  assign dp.ALUsrc     = alusrc;
  assign dp.Immop      = immop;
endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed programs run against a small instruction-level model; each
// cycle of a run is compared with the 3-cycles-per-instruction schedule.
module tb_datapath_sequencer;
  logic clk, rst_n, start, start2;
  logic busy, done, busy2, done2;
  logic [1:0] status, status2;
  logic clr;

  datapath_sequencer_if #(.DATA_WIDTH(32), .ADD_WIDTH(5), .PC_WIDTH(8)) dpi ();
  datapath_sequencer_if #(.DATA_WIDTH(32), .ADD_WIDTH(5), .PC_WIDTH(8)) dpw ();

  datapath_sequencer #(.DATA_WIDTH(32), .ADD_WIDTH(5), .PC_WIDTH(8), .MAX_STEPS(1024)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .status(status), .dp(dpi)
  );
  datapath_sequencer #(.DATA_WIDTH(32), .ADD_WIDTH(5), .PC_WIDTH(8), .MAX_STEPS(4)) dut_wd (
    .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
    .status(status2), .dp(dpw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // environment: ROM, register file, ALU equality
  logic [31:0] rom [64];
  logic [31:0] rf  [32];
  logic [31:0] op2;
  assign op2     = dpi.ALUsrc ? dpi.Immop : rf[dpi.AD2];
  assign dpi.EQ  = (rf[dpi.AD1] == op2);
  assign dpw.EQ  = 1'b0;

  always @(posedge clk) begin
    dpi.instr_data <= rom[dpi.instr_addr[7:2]];
    dpw.instr_data <= 32'h00101063;   // bne x0,x1,0 everywhere
    if (clr) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else if (rst_n && dpi.WE3) begin
      rf[dpi.AD3] <= rf[dpi.AD1] + op2;
    end
  end

  // observation counters
  int wcnt, x10cnt, tcnt, wcnt2;
  logic [4:0]  last_ad3;
  logic [31:0] last_imm;
  logic        last_alusrc;
  always @(negedge clk) begin
    if (clr) begin
      wcnt = 0; x10cnt = 0; tcnt = 0; wcnt2 = 0;
      last_ad3 = '0; last_imm = '0; last_alusrc = 1'b0;
    end else begin
      if (dpi.WE3) begin
        wcnt++;
        if (dpi.AD3 == 5'd10) x10cnt++;
        last_ad3 = dpi.AD3; last_imm = dpi.Immop; last_alusrc = dpi.ALUsrc;
      end
      if (!dpi.ALUsrc && dpi.Immop == 32'hFFFFFFFC && !dpi.EQ) tcnt++;
      if (dpw.WE3) wcnt2++;
    end
  end

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // instruction-level reference model
  typedef struct { logic we; logic [4:0] ad3; logic alusrc; logic [31:0] imm; } rec_t;
  rec_t exp_q[$];
  int   exp_status;

  task automatic iss();
    int m [32];
    int pc, steps, ii, bi, tgt;
    logic [31:0] w;
    logic signed [11:0] i12;
    logic signed [12:0] b13;
    int rd, rs1, rs2;
    for (int i = 0; i < 32; i++) m[i] = 0;
    pc = 0; steps = 0; exp_q.delete();
    while (1) begin
      w   = rom[pc / 4];
      rd  = int'(w[11:7]); rs1 = int'(w[19:15]); rs2 = int'(w[24:20]);
      i12 = w[31:20]; ii = int'(i12);
      b13 = {w[31], w[7], w[30:25], w[11:8], 1'b0}; bi = int'(b13);
      if (w == 32'h00100073) begin
        exp_q.push_back('{1'b0, 5'd0, 1'b0, 32'd0}); exp_status = 0; break;
      end else if (w[6:0] == 7'h13 && w[14:12] == 3'd0) begin
        exp_q.push_back('{rd != 0, 5'(rd), 1'b1, 32'(ii)});
        if (rd != 0) m[rd] = m[rs1] + ii;
        pc = (pc + 4) % 256;
      end else if (w[6:0] == 7'h33 && w[14:12] == 3'd0 && w[31:25] == 7'd0) begin
        exp_q.push_back('{rd != 0, 5'(rd), 1'b0, 32'd0});
        if (rd != 0) m[rd] = m[rs1] + m[rs2];
        pc = (pc + 4) % 256;
      end else if (w[6:0] == 7'h63 && w[14:12] == 3'd1) begin
        exp_q.push_back('{1'b0, 5'd0, 1'b0, 32'(bi)});
        if (m[rs1] != m[rs2]) begin
          tgt = (pc + bi) & 255;
          if (tgt % 4 != 0) begin exp_status = 2; break; end
          pc = tgt;
        end else pc = (pc + 4) % 256;
      end else begin
        exp_q.push_back('{1'b0, 5'd0, 1'b0, 32'd0}); exp_status = 1; break;
      end
      steps++;
      if (steps == 1024) begin exp_status = 3; break; end
    end
  endtask

  task automatic clear_env();
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
  endtask

  // compare process: run a program and check every cycle against the model
  task automatic run1();
    int n;
    rec_t r;
    iss();
    n = exp_q.size();
    clear_env();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k <= 3 * n + 1; k++) begin
      if (k > 0) @(negedge clk);
      if (k < 3 * n) begin
        chk("busy", 32'(busy), 32'd1);
        chk("done_low", 32'(done), 32'd0);
        if (k % 3 == 2) begin
          r = exp_q[k / 3];
          chk("exec_we3", 32'(dpi.WE3), 32'(r.we));
          if (r.we) chk("exec_ad3", 32'(dpi.AD3), 32'(r.ad3));
          chk("exec_alusrc", 32'(dpi.ALUsrc), 32'(r.alusrc));
          chk("exec_immop", dpi.Immop, r.imm);
        end else begin
          chk("idle_we3", 32'(dpi.WE3), 32'd0);
          chk("idle_alusrc", 32'(dpi.ALUsrc), 32'd0);
          chk("idle_immop", dpi.Immop, 32'd0);
        end
      end else begin
        chk("done", 32'(done), 32'd1);
        chk("busy_low", 32'(busy), 32'd0);
        if (k == 3 * n) chk("status", 32'(status), 32'(exp_status));
      end
    end
  endtask

  task automatic load(input logic [31:0] w0, input logic [31:0] w1,
                      input logic [31:0] w2, input logic [31:0] w3);
    for (int i = 0; i < 64; i++) rom[i] = 32'd0;
    rom[0] = w0; rom[1] = w1; rom[2] = w2; rom[3] = w3;
  endtask

  initial begin
    int k;
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0; clr = 1'b0;
    load(32'd0, 32'd0, 32'd0, 32'd0);
    clear_env();
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_status", 32'(status), 32'd0);
    chk("rst_we3", 32'(dpi.WE3), 32'd0);
    chk("rst_alusrc", 32'(dpi.ALUsrc), 32'd0);
    chk("rst_immop", dpi.Immop, 32'd0);
    chk("rst_ad", 32'({dpi.AD1, dpi.AD2, dpi.AD3}), 32'd0);
    chk("rst_addr", 32'(dpi.instr_addr), 32'd0);
    chk("rst_wd_busy", 32'(busy2), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // addi x10,x0,5 ; ebreak
    load(32'h00500513, 32'h00100073, 32'd0, 32'd0);
    run1();
    chk("t1_wcnt", 32'(wcnt), 32'd1);
    chk("t1_ad3", 32'(last_ad3), 32'd10);
    chk("t1_alusrc", 32'(last_alusrc), 32'd1);
    chk("t1_imm", last_imm, 32'd5);
    chk("t1_x10", rf[10], 32'd5);

    // addi x11,x0,3 ; addi x10,x10,1 ; bne x10,x11,-4 ; ebreak
    load(32'h00300593, 32'h00150513, 32'hFEB51EE3, 32'h00100073);
    run1();
    chk("t2_x10_writes", 32'(x10cnt), 32'd3);
    chk("t2_taken", 32'(tcnt), 32'd2);
    chk("t2_final_pc", 32'(dpi.instr_addr), 32'd12);
    chk("t2_x10", rf[10], 32'd3);
    chk("t2_status", 32'(status), 32'd0);

    // addi x5,x0,-1 ; ebreak
    load(32'hFFF00293, 32'h00100073, 32'd0, 32'd0);
    run1();
    chk("t3_imm", last_imm, 32'hFFFFFFFF);
    chk("t3_ad3", 32'(last_ad3), 32'd5);

    // illegal all-zero word
    load(32'h00000000, 32'd0, 32'd0, 32'd0);
    run1();
    chk("t4_status", 32'(status), 32'd1);
    chk("t4_wcnt", 32'(wcnt), 32'd0);

    // addi x0,x0,7 ; ebreak
    load(32'h00700013, 32'h00100073, 32'd0, 32'd0);
    run1();
    chk("t5_wcnt", 32'(wcnt), 32'd0);
    chk("t5_status", 32'(status), 32'd0);

    // addi x1,x0,1 ; bne x0,x1,+6 -> misaligned target, pc stays 4
    load(32'h00100093, 32'h00101363, 32'd0, 32'd0);
    run1();
    chk("t6_status", 32'(status), 32'd2);
    chk("t6_pc", 32'(dpi.instr_addr), 32'd4);

    // watchdog instance: bne x0,x1,0 with EQ held low, MAX_STEPS=4
    clear_env();
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    k = 0;
    while (!done2 && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("wd_cycles", 32'(k), 32'd12);
    chk("wd_status", 32'(status2), 32'd3);
    chk("wd_busy", 32'(busy2), 32'd0);
    chk("wd_pc", 32'(dpw.instr_addr), 32'd0);
    chk("wd_wcnt", 32'(wcnt2), 32'd0);

    // add x3,x1,x2 interrupted by reset in its EXEC cycle
    load(32'h002081B3, 32'h00100073, 32'd0, 32'd0);
    clear_env();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("t8_we3_exec", 32'(dpi.WE3), 32'd1);
    chk("t8_ad3_exec", 32'(dpi.AD3), 32'd3);
    #1 rst_n = 1'b0;
    #1;
    chk("t8_we3_rst", 32'(dpi.WE3), 32'd0);
    chk("t8_busy_rst", 32'(busy), 32'd0);
    chk("t8_done_rst", 32'(done), 32'd0);
    chk("t8_pc_rst", 32'(dpi.instr_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // restart from pc 0 after reset
    load(32'h00500513, 32'h00100073, 32'd0, 32'd0);
    run1();
    chk("t9_wcnt", 32'(wcnt), 32'd1);
    chk("t9_x10", rf[10], 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
- Multi-cycle controller that runs a small RV32I subset (addi, add, bne, ebreak) on the register-file/ALU datapath.
- Fetches instruction words from a synchronous instruction ROM and decodes them.
- Drives AD1/AD2/AD3/WE3/ALUsrc/Immop and consumes EQ for branches.
- Sits between the instruction ROM and the datapath top; a start/done handshake lets a testbench or host launch a program run.

Parameters:
- DATA_WIDTH, 32, datapath word width.
- ADD_WIDTH, 5, register address width.
- PC_WIDTH, 8, byte-address width of instruction ROM; PC wraps modulo 2^PC_WIDTH.
- MAX_STEPS, 1024, watchdog limit on executed instructions per run.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  launch run from PC 0; sampled only in IDLE.
- busy  out  1  high from the cycle after start until done.
- done  out  1  level; high after run ends, cleared by next accepted start.
- status  out  2  00 ebreak, 01 illegal opcode, 10 misaligned branch, 11 watchdog timeout; valid while done.
- instr_addr  out  PC_WIDTH  ROM byte address.
- instr_data  in  32  ROM data, one-cycle read latency.
- AD1, AD2, AD3  out  ADD_WIDTH  rs1, rs2, rd to register file.
- WE3  out  1  register write enable.
- ALUsrc  out  1  1 = Immop into ALU operand 2.
- Immop  out  DATA_WIDTH  sign-extended immediate.
- EQ  in  1  ALU equality flag (RD1 == ALUop2).

Behaviour:
- Reset (async, any state): IDLE; pc=0, ir=0, step count=0, busy=0, done=0, status=00, WE3=0, ALUsrc=0, AD*=0, Immop=0, instr_addr=0. A reset mid-write suppresses that WE3 immediately.
- States: IDLE, FETCH, DECODE, EXEC, DONE.
- IDLE:
  - start=1 clears done, pc, and step count, then moves to FETCH.
  - start in any other state is ignored.
- FETCH: instr_addr=pc; moves to DECODE.
- DECODE: ir<=instr_data; moves to EXEC.
- EXEC: one cycle; outputs are combinational from ir; each instruction costs 3 cycles.
  - addi (opcode 0010011, funct3 000): AD1=rs1, AD3=rd, ALUsrc=1, Immop=sext(ir[31:20]), WE3=(rd!=0); pc+=4.
  - add (0110011, funct3 000, funct7 0): AD1=rs1, AD2=rs2, AD3=rd, ALUsrc=0, WE3=(rd!=0); pc+=4.
  - bne (1100011, funct3 001): AD1=rs1, AD2=rs2, ALUsrc=0, WE3=0, Immop=B-imm (sext of {ir[31],ir[7],ir[30:25],ir[11:8],0}).
    - EQ=1: pc+=4.
    - EQ=0: pc+=B-imm, truncated to PC_WIDTH.
    - Taken branch with target[1:0]!=0: DONE with status 10; pc unchanged.
  - ebreak (ir==32'h00100073): DONE, status 00.
  - Any other word: DONE, status 01, WE3=0.
  - After each retired instruction the step count increments. When the count reaches MAX_STEPS, go to DONE with status 11 instead of FETCH; the last instruction still retires.
- DONE: done=1, busy=0; moves to IDLE in the same cycle. done holds until the next start.
- Outside EXEC: WE3=0, ALUsrc=0, Immop=0; AD* hold their last values.
- pc+4 past 2^PC_WIDTH-4 wraps to 0.
- Branch offsets use two's-complement add.
- Write to x0: WE3 is forced to 0.

Decomposition:
- Package seq_pkg:
  - opcode constants OP_IMM, OP_REG, OP_BRANCH.
  - funct3 constants.
  - EBREAK word.
  - state_t enum.
  - status_t enum (ST_OK, ST_ILLEGAL, ST_MISALIGN, ST_TIMEOUT).
- Sub-module imm_gen: combinational; ir in; I-imm and B-imm out, both DATA_WIDTH sign-extended.

Test Plan:
- Reset/start: ROM[0]=addi x10,x0,5 (0x00500513), ROM[4]=ebreak; start pulse.
  - Exactly one WE3 pulse with AD3=10, ALUsrc=1, Immop=5.
  - done=1, status=00 after 6 cycles.
- Loop: addi x11,x0,3; addi x10,x10,1; bne x10,x11,-4; ebreak.
  - Three WE3 writes to x10.
  - Two taken branches back to pc 4; final pc 12.
  - status=00.
- Negative immediate: addi x5,x0,-1 (0xFFF00293) → Immop=0xFFFFFFFF, AD3=5.
- Illegal and x0: word 0x00000000 → status=01, no WE3. addi x0,x0,7 → WE3 stays 0.
- Watchdog: MAX_STEPS=4, bne x0,x1,0 with EQ forced 0 → status=11 after exactly 4 steps.
- Async reset asserted during EXEC of an add → WE3 drops 0 immediately; busy=0; restart runs from pc 0.
